register_file_mp: RTL

Parametrised multi-port register file, the successor to the single-write, dual-read core register file. It provides configurable width, depth and read/write port counts, with deterministic write-conflict priority and a hardwired zero register. A per-register busy scoreboard lets the pipeline detect reads of values whose producer is still in flight. One instance sits in the decode/writeback stage of each core.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/register_file_mp_if.sv | 31 +++
 rtl/rf_scoreboard.sv | 37 +++
 rtl/register_file_mp.sv | 77 +++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry, word/select types
// and the write-port priority select used by the data path.
package rf_pkg;

  localparam int unsigned RF_WIDTH  = 32;
  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_AW     = $clog2(RF_DEPTH);
  localparam int unsigned RF_MAX_WR = 4;
  localparam int unsigned RF_PSEL_W = 2;

  typedef logic [RF_AW-1:0]    regsel_t;
  typedef logic [RF_WIDTH-1:0] word_t;

  // Highest-index asserted bit wins; callers gate the result with their own any-hit flag.
  function automatic logic [RF_PSEL_W-1:0] rf_prio_sel(input logic [RF_MAX_WR-1:0] hit);
    rf_prio_sel = '0;
    for (int k = 0; k < RF_MAX_WR; k++) begin
      if (hit[k]) rf_prio_sel = RF_PSEL_W'(k);
    end
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Read, write, issue and scoreboard signals of the multi-port register file.
interface register_file_mp_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NREAD-1:0][AW-1:0]     rsel;
  logic [NREAD-1:0][WIDTH-1:0]  rdat;
  logic [NREAD-1:0]             rbusy;
  logic [NWRITE-1:0]            wen;
  logic [NWRITE-1:0][AW-1:0]    wsel;
  logic [NWRITE-1:0][WIDTH-1:0] wdat;
  logic                         iss_en;
  logic [AW-1:0]                iss_sel;
  logic                         flush;
  logic [DEPTH-1:0]             busy_vec;

  modport master (
    output rsel, wen, wsel, wdat, iss_en, iss_sel, flush,
    input  rdat, rbusy, busy_vec
  );

  modport slave (
    input  rsel, wen, wsel, wdat, iss_en, iss_sel, flush,
    output rdat, rbusy, busy_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard. Priority on an edge: reset, then flush, then issue-set,
// then write-clear. Register 0 is never marked busy.
module rf_scoreboard #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DEPTH-1:0] i_wr_hit,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_sel,
  input  logic             i_flush,
  output logic [DEPTH-1:0] o_busy_vec
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_d;

  always_comb begin
    w_busy_d = r_busy;
    if (i_flush) begin
      w_busy_d = '0;
    end else begin
      w_busy_d = r_busy & ~i_wr_hit;
      // A same-edge issue means a newer producer, so it beats the clear.
      if (i_iss_en && (i_iss_sel != '0)) w_busy_d[i_iss_sel] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_d;
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with hardwired zero register and busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2
) (
  input logic               CLK,
  input logic               RST,
  register_file_mp_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem      [DEPTH];
  logic [RF_MAX_WR-1:0] w_port_hit [DEPTH];
  logic [RF_PSEL_W-1:0] w_win      [DEPTH];
  logic [WIDTH-1:0]     w_wr_data  [DEPTH];
  logic [DEPTH-1:0]     w_wr_hit;
  logic [DEPTH-1:0]     w_busy_vec;

  // Per-register write decode: which ports hit it, and the winning port's data.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      w_port_hit[r] = '0;
      for (int k = 0; k < NWRITE; k++) begin
        w_port_hit[r][k] = bus.wen[k] && (bus.wsel[k] == AW'(r));
      end
      w_wr_hit[r]  = (r != 0) && (|w_port_hit[r]);
      w_win[r]     = rf_prio_sel(w_port_hit[r]);
      w_wr_data[r] = '0;
      for (int k = 0; k < NWRITE; k++) begin
        if (w_win[r] == RF_PSEL_W'(k)) w_wr_data[r] = bus.wdat[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (RST || (r == 0)) r_mem[r] <= '0;
      else if (w_wr_hit[r]) r_mem[r] <= w_wr_data[r];
    end
  end

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_wr_hit   (w_wr_hit),
    .i_iss_en   (bus.iss_en),
    .i_iss_sel  (bus.iss_sel),
    .i_flush    (bus.flush),
    .o_busy_vec (w_busy_vec)
  );

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      bus.rdat[i]  = r_mem[bus.rsel[i]];
      bus.rbusy[i] = (bus.rsel[i] != '0) && w_busy_vec[bus.rsel[i]];
`ifdef RF_BYPASS_EN
      // w_wr_hit[0] is never set, so the zero register is never forwarded.
      if (w_wr_hit[bus.rsel[i]]) begin
        bus.rdat[i]  = w_wr_data[bus.rsel[i]];
        bus.rbusy[i] = 1'b0;
      end
`endif
    end
  end

  assign bus.busy_vec = w_busy_vec;

endmodule
